// File: rtl/synapse_scheduler_if.sv
// synapse_scheduler_if: result handshake toward the neuron update stage.
interface synapse_scheduler_if #(
    parameter int NW = 4
);
    logic          valid;
    logic          ready;
    logic [NW-1:0] neuron;
    logic [15:0]   sum;

    modport master (output valid, neuron, sum, input ready);
    modport slave  (input valid, neuron, sum, output ready);
endinterface

// File: rtl/synapse_scheduler.sv
// synapse_scheduler: per-tick neuron/axon sweep feeding the synapse unit.
// Optional macro SYN_SCHED_SKIP_EN: visit only active axons.
module synapse_scheduler #(
    parameter int         N_AXONS   = 16,
    parameter int         N_NEURONS = 16,
    parameter logic [7:0] LFSR_SEED = 8'hA5,
    localparam int        NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic [N_AXONS-1:0]   axon_spikes,
    input  logic [2*N_AXONS-1:0] axon_types,
    output logic [NW-1:0]        xbar_rd_addr,
    input  logic [N_AXONS-1:0]   xbar_rd_data,
    input  logic [20:0]          param_rd_data,
    output logic [7:0]           syn_neuron_instruction,
    output logic                 syn_sign_select,
    output logic [3:0]           syn_synaptic_weights,
    output logic                 syn_stoch_det_mode_select,
    output logic [7:0]           syn_random_number,
    input  logic [7:0]           syn_synapse_output,
    synapse_scheduler_if.master  res,
    output logic                 busy,
    output logic                 done,
    output logic                 tick_overrun
);
    localparam int AW = (N_AXONS > 1) ? $clog2(N_AXONS) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, INTEG, EMIT, DONE} state_t;

    state_t               state, state_nx;
    logic [N_AXONS-1:0]   spikes_q, row_q;
    logic [2*N_AXONS-1:0] types_q;
    logic [20:0]          param_q;
    logic [NW-1:0]        n_q;
    logic [15:0]          acc_q, acc_sat;
    logic [16:0]          sum_w;
    logic [7:0]           lfsr_q, lfsr_nx;
    logic                 overrun_q;
    logic [AW-1:0]        a_cur;
    logic                 last_axon, act, sign, in_integ, last_n;
    logic [1:0]           typ;
    logic [3:0]           weight;

`ifdef SYN_SCHED_SKIP_EN
    logic [N_AXONS-1:0] mask_q;
    logic [N_AXONS-1:0] a_onehot;

    // Lowest-index active axon still pending in this neuron's row
    always_comb begin
        a_cur = '0;
        for (int i = N_AXONS - 1; i >= 0; i--)
            if (mask_q[i]) a_cur = AW'(i);
    end
    assign a_onehot  = N_AXONS'(1) << a_cur;
    assign last_axon = (mask_q & ~a_onehot) == '0;

    always_ff @(posedge clk) begin
        if (rst) mask_q <= '0;
        else if (state == LOAD) mask_q <= spikes_q & xbar_rd_data;
        else if (state == INTEG) mask_q <= mask_q & ~a_onehot;
    end
`else
    logic [AW-1:0] a_q;

    assign a_cur     = a_q;
    assign last_axon = a_q == AW'(N_AXONS - 1);

    always_ff @(posedge clk) begin
        if (rst) a_q <= '0;
        else if (state == LOAD) a_q <= '0;
        else if (state == INTEG) a_q <= a_q + 1'b1;
    end
`endif

    assign in_integ = state == INTEG;
    assign last_n   = n_q == NW'(N_NEURONS - 1);
    assign typ      = types_q[{a_cur, 1'b0} +: 2];
    assign act      = spikes_q[a_cur] & row_q[a_cur];
    assign weight   = param_q[{typ, 2'b00} +: 4];
    assign sign     = param_q[5'd16 + {3'b0, typ}];

    assign sum_w   = {acc_q[15], acc_q} + {{9{syn_synapse_output[7]}}, syn_synapse_output};
    assign acc_sat = (sum_w[16] != sum_w[15]) ? (sum_w[16] ? 16'h8000 : 16'h7FFF)
                                              : sum_w[15:0];
    assign lfsr_nx = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    assign syn_neuron_instruction    = {7'b0, in_integ & act};
    assign syn_sign_select           = in_integ & sign;
    assign syn_synaptic_weights      = in_integ ? weight : 4'd0;
    assign syn_stoch_det_mode_select = in_integ & param_q[20];
    assign syn_random_number         = lfsr_q;
    assign xbar_rd_addr              = (state == FETCH) ? n_q : '0;

    assign res.valid    = state == EMIT;
    assign res.neuron   = (state == EMIT) ? n_q : '0;
    assign res.sum      = (state == EMIT) ? acc_q : 16'd0;
    assign busy         = state != IDLE;
    assign done         = state == DONE;
    assign tick_overrun = overrun_q;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (tick) state_nx = FETCH;
            FETCH: state_nx = LOAD;
`ifdef SYN_SCHED_SKIP_EN
            LOAD:  state_nx = |(spikes_q & xbar_rd_data) ? INTEG : EMIT;
`else
            LOAD:  state_nx = INTEG;
`endif
            INTEG: if (last_axon) state_nx = EMIT;
            EMIT:  if (res.ready) state_nx = last_n ? DONE : FETCH;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            spikes_q  <= '0;
            types_q   <= '0;
            row_q     <= '0;
            param_q   <= '0;
            n_q       <= '0;
            acc_q     <= '0;
            lfsr_q    <= LFSR_SEED;
            overrun_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (tick && state != IDLE) overrun_q <= 1'b1;
            if (state == IDLE && tick) begin
                spikes_q <= axon_spikes;
                types_q  <= axon_types;
                n_q      <= '0;
            end
            if (state == LOAD) begin
                row_q   <= xbar_rd_data;
                param_q <= param_rd_data;
                acc_q   <= '0;
            end
            if (in_integ) begin
                acc_q  <= acc_sat;
                lfsr_q <= lfsr_nx;
            end
            if (state == EMIT && res.ready && !last_n) n_q <= n_q + 1'b1;
        end
    end
endmodule
